// File: rtl/simon_iterative_core.sv
// Iterative SIMON 2N/MN core: expands the key once into a T-entry round-key store, then runs one round per clock.
// Optional feature macro: SIMON_DECRYPT_EN adds the decrypt port, reverse key order and the inverse round.
module simon_iterative_core #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int J = 0,
  parameter int C = 5
) (
  input  logic                clk,
  input  logic                R,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] key,
  input  logic                newData,
`ifdef SIMON_DECRYPT_EN
  input  logic                decrypt,
`endif
  input  logic [2*N-1:0]      plain,
  input  logic                readData,
  output logic                doneKey,
  output logic                doneData,
  output logic [2*N-1:0]      cipher
);

  typedef enum logic [2:0] {S_NOKEY, S_KEYEXP, S_READY, S_RUN, S_DONE} state_t;

  // z sequences written first-bit-leftmost, then reversed so bit i of Z_LSB is z_J[i].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  function automatic logic [61:0] rev62(input logic [61:0] v);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) r[i] = v[61-i];
    return r;
  endfunction

  localparam logic [61:0] Z_SEL = (J == 0) ? Z0 : (J == 1) ? Z1 : (J == 2) ? Z2 : (J == 3) ? Z3 : Z4;
  localparam logic [61:0] Z_LSB = rev62(Z_SEL);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return rol(v, N - s);
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  state_t         r_state;
  logic [C-1:0]   r_cnt;
  logic           r_key_q, r_data_q, r_last;
  logic           r_done_key, r_done_data;
  logic [2*N-1:0] r_cipher;
  logic [N-1:0]   r_x, r_y;
  logic [N-1:0]   r_rk [T];
`ifdef SIMON_DECRYPT_EN
  logic           r_dec;
`endif

  logic           w_key_edge, w_data_edge, w_load_key, w_start;
  logic [5:0]     w_zi;
  logic [N-1:0]   w_tmp, w_rk_new, w_rk_rd, w_nx, w_ny;
  logic [C-1:0]   w_rd_idx;

  assign w_key_edge  = newKey & ~r_key_q;
  assign w_data_edge = newData & ~r_data_q;
  assign w_load_key  = w_key_edge && (r_state == S_NOKEY || r_state == S_READY);
  assign w_start     = w_data_edge && !w_key_edge && r_state == S_READY;
  assign w_zi        = 6'((32'(r_cnt) - 32'(M)) % 32'd62);

  always_comb begin
    // NOTE: blocking assignments here so each line sees the previous partial value of w_tmp;
    // every output is assigned on every path, so no latch is inferred.
    w_tmp = ror(r_rk[r_cnt - C'(1)], 3);
    if (M == 4) w_tmp = w_tmp ^ r_rk[r_cnt - C'(3)];
    w_tmp    = w_tmp ^ ror(w_tmp, 1);
    w_rk_new = ~r_rk[r_cnt - C'(M)] ^ w_tmp ^ N'(3) ^ {{(N-1){1'b0}}, Z_LSB[w_zi]};
  end

`ifdef SIMON_DECRYPT_EN
  assign w_rd_idx = r_dec ? C'(T - 1) - r_cnt : r_cnt;
`else
  assign w_rd_idx = r_cnt;
`endif
  assign w_rk_rd = r_rk[w_rd_idx];

  always_comb begin
    w_nx = r_y ^ f(r_x) ^ w_rk_rd;
    w_ny = r_x;
`ifdef SIMON_DECRYPT_EN
    if (r_dec) begin
      w_nx = r_y;
      w_ny = r_x ^ f(r_y) ^ w_rk_rd;
    end
`endif
  end

  // NOTE: the round-key store and block registers carry no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (w_load_key) begin
      for (int i = 0; i < M; i++) r_rk[i] <= key[i];
    end else if (r_state == S_KEYEXP) begin
      r_rk[r_cnt] <= w_rk_new;
    end
    if (w_start) begin
      r_x <= plain[2*N-1:N];
      r_y <= plain[N-1:0];
`ifdef SIMON_DECRYPT_EN
      r_dec <= decrypt;
`endif
    end else if (r_state == S_RUN && !r_last) begin
      r_x <= w_nx;
      r_y <= w_ny;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_state     <= S_NOKEY;
      r_cnt       <= '0;
      r_key_q     <= 1'b0;
      r_data_q    <= 1'b0;
      r_last      <= 1'b0;
      r_done_key  <= 1'b0;
      r_done_data <= 1'b0;
      r_cipher    <= '0;
    end else begin
      r_key_q  <= newKey;
      r_data_q <= newData;
      case (r_state)
        S_NOKEY: if (w_key_edge) begin
          r_cnt   <= C'(M);
          r_state <= S_KEYEXP;
        end
        S_KEYEXP: if (r_cnt == C'(T - 1)) begin
          r_done_key <= 1'b1;
          r_state    <= S_READY;
        end else begin
          r_cnt <= r_cnt + C'(1);
        end
        S_READY: if (w_key_edge) begin
          r_done_key <= 1'b0;
          r_cnt      <= C'(M);
          r_state    <= S_KEYEXP;
        end else if (w_data_edge) begin
          r_cnt   <= '0;
          r_last  <= 1'b0;
          r_state <= S_RUN;
        end
        // The final round lands in r_x/r_y; the following edge publishes it.
        S_RUN: if (r_last) begin
          r_cipher    <= {r_x, r_y};
          r_done_data <= 1'b1;
          r_last      <= 1'b0;
          r_state     <= S_DONE;
        end else if (r_cnt == C'(T - 1)) begin
          r_last <= 1'b1;
        end else begin
          r_cnt <= r_cnt + C'(1);
        end
        S_DONE: if (readData) begin
          r_done_data <= 1'b0;
          r_state     <= S_READY;
        end
        default: r_state <= S_NOKEY;
      endcase
    end
  end

  assign doneKey  = r_done_key;
  assign doneData = r_done_data;
  assign cipher   = r_cipher;

endmodule

// File: tb/tb_simon_iterative_core.sv
// Directed bench for simon_iterative_core: SIMON32/64 and SIMON64/128 vectors plus handshake corner cases.
// Define SIMON_DECRYPT_EN to also exercise the decrypt path.
`timescale 1ns/1ps
module tb_simon_iterative_core;

  localparam int BUDGET = 200;
  localparam logic [3:0][15:0] K16 = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
  localparam logic [3:0][31:0] K64 = {32'h1b1a1918, 32'h13121110, 32'h0b0a0908, 32'h03020100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic R = 1'b1, readData = 1'b0, decrypt = 1'b0;
  logic newKey = 1'b0, newData = 1'b0, doneKey, doneData;
  logic [3:0][15:0] key = K16;
  logic [31:0] plain = '0, cipher;
  logic newKey64 = 1'b0, newData64 = 1'b0, doneKey64, doneData64;
  logic [3:0][31:0] key64 = K64;
  logic [63:0] plain64 = '0, cipher64;

  int vectors = 0;
  int miscompares = 0;

  simon_iterative_core u_dut (
    .clk(clk), .R(R), .newKey(newKey), .key(key), .newData(newData),
`ifdef SIMON_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .plain(plain), .readData(readData),
    .doneKey(doneKey), .doneData(doneData), .cipher(cipher)
  );

  simon_iterative_core #(.N(32), .M(4), .T(44), .J(3), .C(6)) u_dut64 (
    .clk(clk), .R(R), .newKey(newKey64), .key(key64), .newData(newData64),
`ifdef SIMON_DECRYPT_EN
    .decrypt(decrypt),
`endif
    .plain(plain64), .readData(readData),
    .doneKey(doneKey64), .doneData(doneData64), .cipher(cipher64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    readData = 1'b1;
    tick();
    readData = 1'b0;
  endtask

  // Pulses newKey; n = clocks after the sampling edge until doneKey is seen (-1 on timeout).
  task automatic load_key16(output int n);
    key    = K16;
    newKey = 1'b1;
    tick();
    newKey = 1'b0;
    n = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      tick();
      if (doneKey) begin n = i; break; end
    end
  endtask

  // Pulses newData; decrypt flips right after the sampling edge and must not matter.
  task automatic run16(input logic [31:0] p, input logic d, output int n);
    plain   = p;
    decrypt = d;
    newData = 1'b1;
    tick();
    newData = 1'b0;
    decrypt = ~d;
    n = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      tick();
      if (doneData) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    logic seen;
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    vectors++;
    if (doneKey !== 1'b0) begin $display("FAIL reset_doneKey: got %b expected 0", doneKey); miscompares++; end
    vectors++;
    if (doneData !== 1'b0) begin $display("FAIL reset_doneData: got %b expected 0", doneData); miscompares++; end
    vectors++;
    if (cipher !== 32'h0) begin $display("FAIL reset_cipher: got %h expected 00000000", cipher); miscompares++; end
    newData = 1'b1;
    tick();
    newData = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (doneData) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin $display("FAIL nokey_ignores_data: got doneData %b expected 0", seen); miscompares++; end
  endtask

  task automatic test_key_expansion();
    int n;
    load_key16(n);
    vectors++;
    if (n !== 28) begin $display("FAIL keyexp_latency: got %0d expected 28", n); miscompares++; end
    vectors++;
    if (doneKey !== 1'b1) begin $display("FAIL keyexp_doneKey: got %b expected 1", doneKey); miscompares++; end
  endtask

  task automatic test_encrypt();
    int n;
    run16(32'h65656877, 1'b0, n);
    vectors++;
    if (n !== 33) begin $display("FAIL enc_latency: got %0d expected 33", n); miscompares++; end
    vectors++;
    if (cipher !== 32'hc69be9bb) begin $display("FAIL enc_cipher: got %h expected c69be9bb", cipher); miscompares++; end
    repeat (3) tick();
    vectors++;
    if (doneData !== 1'b1 || cipher !== 32'hc69be9bb) begin
      $display("FAIL done_hold: got doneData %b cipher %h expected 1 c69be9bb", doneData, cipher); miscompares++;
    end
    ack();
    vectors++;
    if (doneData !== 1'b0) begin $display("FAIL ack_doneData: got %b expected 0", doneData); miscompares++; end
    vectors++;
    if (cipher !== 32'hc69be9bb) begin $display("FAIL ack_cipher_kept: got %h expected c69be9bb", cipher); miscompares++; end
  endtask

  task automatic test_back_to_back();
    int n;
    logic seen;
    plain   = 32'h65656877;
    decrypt = 1'b0;
    newData = 1'b1;
    tick();
    repeat (4) tick();
    newData = 1'b0;
    n = -1;
    for (int i = 5; i <= BUDGET; i++) begin
      tick();
      if (doneData) begin n = i; break; end
    end
    vectors++;
    if (n !== 33) begin $display("FAIL held_latency: got %0d expected 33", n); miscompares++; end
    vectors++;
    if (cipher !== 32'hc69be9bb) begin $display("FAIL held_cipher: got %h expected c69be9bb", cipher); miscompares++; end
    ack();
    seen = 1'b0;
    repeat (40) begin tick(); if (doneData) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin $display("FAIL held_single_block: got second doneData %b expected 0", seen); miscompares++; end
    run16(32'h65656877, 1'b0, n);
    vectors++;
    if (n !== 33 || cipher !== 32'hc69be9bb) begin
      $display("FAIL rerun: got latency %0d cipher %h expected 33 c69be9bb", n, cipher); miscompares++;
    end
    ack();
  endtask

  task automatic test_key_data_collision();
    int n;
    logic seen;
    key     = K16;
    plain   = 32'h65656877;
    newKey  = 1'b1;
    newData = 1'b1;
    tick();
    newKey  = 1'b0;
    newData = 1'b0;
    vectors++;
    if (doneKey !== 1'b0) begin $display("FAIL collide_doneKey_drop: got %b expected 0", doneKey); miscompares++; end
    n = -1;
    seen = 1'b0;
    for (int i = 1; i <= BUDGET; i++) begin
      tick();
      if (doneData) seen = 1'b1;
      if (doneKey) begin n = i; break; end
    end
    repeat (40) begin tick(); if (doneData) seen = 1'b1; end
    vectors++;
    if (n !== 28) begin $display("FAIL collide_key_latency: got %0d expected 28", n); miscompares++; end
    vectors++;
    if (seen !== 1'b0) begin $display("FAIL collide_data_dropped: got doneData %b expected 0", seen); miscompares++; end
  endtask

`ifdef SIMON_DECRYPT_EN
  task automatic test_decrypt();
    int n;
    run16(32'hc69be9bb, 1'b1, n);
    vectors++;
    if (n !== 33) begin $display("FAIL dec_latency: got %0d expected 33", n); miscompares++; end
    vectors++;
    if (cipher !== 32'h65656877) begin $display("FAIL dec_cipher: got %h expected 65656877", cipher); miscompares++; end
    ack();
  endtask
`endif

  task automatic test_wide();
    int n;
    key64    = K64;
    newKey64 = 1'b1;
    tick();
    newKey64 = 1'b0;
    n = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      tick();
      if (doneKey64) begin n = i; break; end
    end
    vectors++;
    if (n !== 40) begin $display("FAIL wide_key_latency: got %0d expected 40", n); miscompares++; end
    plain64   = 64'h656b696c_20646e75;
    decrypt   = 1'b0;
    newData64 = 1'b1;
    tick();
    newData64 = 1'b0;
    n = -1;
    for (int i = 1; i <= BUDGET; i++) begin
      tick();
      if (doneData64) begin n = i; break; end
    end
    vectors++;
    if (n !== 45) begin $display("FAIL wide_latency: got %0d expected 45", n); miscompares++; end
    vectors++;
    if (cipher64 !== 64'h44c8fc20_b9dfa07a) begin
      $display("FAIL wide_cipher: got %h expected 44c8fc20b9dfa07a", cipher64); miscompares++;
    end
    ack();
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen;
    plain   = 32'h65656877;
    decrypt = 1'b0;
    newData = 1'b1;
    tick();
    newData = 1'b0;
    repeat (10) tick();
    R = 1'b1;
    tick();
    R = 1'b0;
    vectors++;
    if (doneKey !== 1'b0 || doneData !== 1'b0 || cipher !== 32'h0) begin
      $display("FAIL midrun_reset: got doneKey %b doneData %b cipher %h expected 0 0 00000000", doneKey, doneData, cipher);
      miscompares++;
    end
    newData = 1'b1;
    tick();
    newData = 1'b0;
    seen = 1'b0;
    repeat (50) begin tick(); if (doneData || doneKey) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin $display("FAIL midrun_data_ignored: got activity %b expected 0", seen); miscompares++; end
    load_key16(n);
    run16(32'h65656877, 1'b0, n);
    vectors++;
    if (n !== 33 || cipher !== 32'hc69be9bb) begin
      $display("FAIL midrun_recover: got latency %0d cipher %h expected 33 c69be9bb", n, cipher); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_key_expansion();
    test_encrypt();
    test_back_to_back();
    test_key_data_collision();
`ifdef SIMON_DECRYPT_EN
    test_decrypt();
`endif
    test_wide();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
